// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader and its helpers.
package imem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BCNT_W         = 2;

    // Opcode nibble position, shared with the Control block decode.
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 28;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    // Loader FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Extract the opcode nibble of an instruction word.
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [WORD_W-1:0] w);
        return w[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes big-endian into a 32-bit word; first byte lands in [31:24].
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en_i,
    input  logic              clear_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_c
);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;

    // Next shift-register contents and byte position; clear wins over load.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (load_en_i) begin
            shreg_d = {shreg_q[WORD_W-BYTE_W-1:0], byte_i};
            cnt_d   = cnt_q + BCNT_W'(1);
        end
    end

    // Assembly state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o      = shreg_q;
    assign word_full_c = load_en_i && !clear_i &&
                         (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory word by word while holding the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_start,
    input  logic [ADDR_W:0]     in_count,
    input  logic                in_abort,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_byte,
    output logic                out_ready,
    output logic                out_wr_en,
    output logic [ADDR_W-1:0]   out_wr_addr,
    output logic [WORD_W-1:0]   out_wr_data,
    output logic                out_cpu_hold,
    output logic                out_done
);

    localparam int unsigned     CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] CAP   = CNT_W'(1) << ADDR_W;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;

    logic              abort_c;
    logic              asm_load_c;
    logic              asm_clear_c;
    logic              asm_full_c;
    logic [WORD_W-1:0] asm_word;
    logic [ADDR_W:0]   count_clamped_c;

    // Requests larger than the memory are cut to its capacity.
    assign count_clamped_c = (in_count > CAP) ? CAP : in_count;

    // Abort only matters once a load is underway; it also drops any byte offered.
    assign abort_c     = in_abort && (state_q != ST_IDLE);
    assign asm_load_c  = in_valid && (state_q == ST_RECV) && !in_abort;
    assign asm_clear_c = abort_c || ((state_q == ST_IDLE) && in_start);

    imem_loader_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .load_en_i   (asm_load_c),
        .clear_i     (asm_clear_c),
        .byte_i      (in_byte),
        .word_o      (asm_word),
        .word_full_c (asm_full_c)
    );

    // Next-state, word index and held write-port values.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_q == ST_WRITE) begin
            wr_data_d = asm_word;
        end
        if (abort_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_start) begin
                        idx_d   = '0;
                        last_d  = ADDR_W'(count_clamped_c - CNT_W'(1));
                        state_d = (count_clamped_c == '0) ? ST_DONE : ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (asm_full_c) begin
                        state_d   = ST_WRITE;
                        wr_addr_d = idx_q;
                    end
                end
                ST_WRITE: begin
                    if (idx_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_RECV;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State and held-output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            last_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Outputs decode straight from registered state; the assembler is stable during WRITE.
    assign out_ready    = (state_q == ST_RECV);
    assign out_wr_en    = (state_q == ST_WRITE);
    assign out_done     = (state_q == ST_DONE);
    assign out_cpu_hold = (state_q != ST_IDLE);
    assign out_wr_addr  = wr_addr_q;
    assign out_wr_data  = (state_q == ST_WRITE) ? asm_word : wr_data_q;

endmodule
